// File: rtl/my_struct_package.sv
// rtl/my_struct_package.sv - shared command type, dispatcher states and command codes
package my_struct_package;

  typedef struct packed {
    logic [3:0]  n;
    logic [31:0] address;
    logic [2:0]  pid;
    logic [1:0]  rsvd;
  } command_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CLEAR = 2'd2,
    ST_PRINT = 2'd3
  } dispatch_state_t;

  localparam logic [3:0] CMD_READ   = 4'd0;
  localparam logic [3:0] CMD_WRITE  = 4'd1;
  localparam logic [3:0] CMD_IFETCH = 4'd2;
  localparam logic [3:0] CMD_INVAL  = 4'd3;
  localparam logic [3:0] CMD_SNOOP  = 4'd4;
  localparam logic [3:0] CMD_CLEAR  = 4'd8;
  localparam logic [3:0] CMD_PRINT  = 4'd9;

  // Codes 0..4 are the cache operations handed to the processor.
  function automatic logic is_cache_op(input logic [3:0] n);
    return n <= CMD_SNOOP;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - DEPTH-entry command FIFO with occupancy count; DEPTH must be a power of two
module cmd_fifo
  import my_struct_package::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  command_t                 wr_data_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  output command_t                 rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  command_t          mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push, do_pop;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointers are AW bits wide, so the increment wraps modulo DEPTH on its own.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/trace_cmd_dispatch.sv
// rtl/trace_cmd_dispatch.sv - buffers trace commands and issues them to the processor with a done handshake
// Optional statistics counters: TRACE_DISPATCH_STATS_EN
module trace_cmd_dispatch
  import my_struct_package::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  command_t               cmd_in,
  input  logic                   cmd_in_valid,
  output logic                   cmd_in_ready,
  output command_t               instruction,
  output logic                   instr_valid,
  input  logic                   proc_done,
  output logic                   clear_req,
  output logic                   print_req,
  output logic                   illegal_cmd,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy,
  output logic [CNT_W-1:0]       rd_cnt,
  output logic [CNT_W-1:0]       wr_cnt,
  output logic [CNT_W-1:0]       if_cnt
);

  dispatch_state_t state_q;
  command_t        instruction_q, head;
  logic            instr_valid_q, clear_req_q, print_req_q, illegal_cmd_q;
  logic            full, empty, pop;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_data_i (cmd_in),
    .push_i    (cmd_in_valid),
    .pop_i     (pop),
    .rd_data_o (head),
    .count_o   (fifo_count),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign cmd_in_ready = !full;
  assign pop          = (state_q == ST_IDLE) && !empty;
  assign busy         = (state_q != ST_IDLE) || !empty;
  assign instruction  = instruction_q;
  assign instr_valid  = instr_valid_q;
  assign clear_req    = clear_req_q;
  assign print_req    = print_req_q;
  assign illegal_cmd  = illegal_cmd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      instruction_q <= '0;
      instr_valid_q <= 1'b0;
      clear_req_q   <= 1'b0;
      print_req_q   <= 1'b0;
      illegal_cmd_q <= 1'b0;
    end else begin
      clear_req_q   <= 1'b0;
      print_req_q   <= 1'b0;
      illegal_cmd_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            if (is_cache_op(head.n)) begin
              instruction_q <= head;
              instr_valid_q <= 1'b1;
              state_q       <= ST_ISSUE;
            end else if (head.n == CMD_CLEAR) begin
              instruction_q <= head;
              clear_req_q   <= 1'b1;
              state_q       <= ST_CLEAR;
            end else if (head.n == CMD_PRINT) begin
              instruction_q <= head;
              print_req_q   <= 1'b1;
              state_q       <= ST_PRINT;
            end else begin
              illegal_cmd_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (proc_done) begin
            instr_valid_q <= 1'b0;
            state_q       <= ST_IDLE;
          end
        end
        // Clear resets the cache only; queued commands survive it.
        ST_CLEAR: if (proc_done) state_q <= ST_IDLE;
        ST_PRINT: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef TRACE_DISPATCH_STATS_EN
  logic [CNT_W-1:0] rd_cnt_q, wr_cnt_q, if_cnt_q;
  logic [CNT_W-1:0] rd_cnt_d, wr_cnt_d, if_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if_cnt_d = if_cnt_q;
    if (clear_req_q) begin
      rd_cnt_d = '0;
      wr_cnt_d = '0;
      if_cnt_d = '0;
    end else if (pop) begin
      if (head.n == CMD_READ   && rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CNT_W'(1);
      if (head.n == CMD_WRITE  && wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CNT_W'(1);
      if (head.n == CMD_IFETCH && if_cnt_q != '1) if_cnt_d = if_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      if_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      if_cnt_q <= if_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
  assign if_cnt = if_cnt_q;
`else
  assign rd_cnt = '0;
  assign wr_cnt = '0;
  assign if_cnt = '0;
`endif

endmodule

// File: tb/tb_trace_cmd_dispatch.sv
// tb/tb_trace_cmd_dispatch.sv - directed scoreboard bench for trace_cmd_dispatch
module tb_trace_cmd_dispatch;
  import my_struct_package::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  command_t               cmd_in;
  logic                   cmd_in_valid;
  logic                   cmd_in_ready;
  command_t               instruction;
  logic                   instr_valid;
  logic                   proc_done;
  logic                   clear_req, print_req, illegal_cmd;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   busy;
  logic [CNT_W-1:0]       rd_cnt, wr_cnt, if_cnt;

  trace_cmd_dispatch #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_in       (cmd_in),
    .cmd_in_valid (cmd_in_valid),
    .cmd_in_ready (cmd_in_ready),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .proc_done    (proc_done),
    .clear_req    (clear_req),
    .print_req    (print_req),
    .illegal_cmd  (illegal_cmd),
    .fifo_count   (fifo_count),
    .busy         (busy),
    .rd_cnt       (rd_cnt),
    .wr_cnt       (wr_cnt),
    .if_cnt       (if_cnt)
  );

  always #5 clk = ~clk;

  int       errors = 0;
  int       checks = 0;
  int       clr_cnt = 0, prt_cnt = 0, ill_cnt = 0;
  logic     prev_valid = 1'b0;
  command_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // One clock edge, then sample 1ns later; issues are matched against the scoreboard.
  task automatic tick();
    command_t e;
    @(posedge clk);
    #1;
    if (clear_req)   clr_cnt++;
    if (print_req)   prt_cnt++;
    if (illegal_cmd) ill_cnt++;
    if (instr_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("issue_order", 64'(instruction), 64'(e));
      end
    end
    prev_valid = instr_valid;
  endtask

  task automatic push(input logic [3:0] n, input logic [31:0] addr);
    command_t c;
    int       waits;
    logic     acc;
    c = '{n: n, address: addr, pid: addr[2:0], rsvd: 2'b00};
    cmd_in       = c;
    cmd_in_valid = 1'b1;
    waits        = 0;
    acc          = 1'b0;
    while (!acc && waits < 300) begin
      acc = cmd_in_ready;
      if (acc && n <= 4'd4) exp_q.push_back(c);
      tick();
      waits++;
    end
    cmd_in_valid = 1'b0;
    if (!acc) check("push_timeout", 64'(acc), 64'd1);
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    while (busy && w < 300) begin
      tick();
      w++;
    end
    check(tag, 64'(busy), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    command_t c;
    rst          = 1'b1;
    cmd_in       = '0;
    cmd_in_valid = 1'b0;
    proc_done    = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_instruction", 64'(instruction), 64'd0);
    check("rst_instr_valid", 64'(instr_valid), 64'd0);
    check("rst_pulses", 64'({clear_req, print_req, illegal_cmd}), 64'd0);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(cmd_in_ready), 64'd1);

    // Single command with proc_done tied high: 2-edge latency, one cycle valid.
    proc_done = 1'b1;
    push(4'd1, 32'hABCD_EF01);
    check("lat_count_after_push", 64'(fifo_count), 64'd1);
    check("lat_not_yet_valid", 64'(instr_valid), 64'd0);
    tick();
    check("lat_valid_e1", 64'(instr_valid), 64'd1);
    check("lat_addr_e1", 64'(instruction.address), 64'hABCD_EF01);
    tick();
    check("lat_valid_e2", 64'(instr_valid), 64'd0);
    check("lat_sb_empty", 64'(exp_q.size()), 64'd0);

    // Fill: 1 in ISSUE + 8 in the FIFO while the processor stalls.
    proc_done = 1'b0;
    for (int i = 0; i < 9; i++) push(4'(i % 3), 32'h1000 + 32'(i));
    check("full_count", 64'(fifo_count), 64'd8);
    check("full_ready", 64'(cmd_in_ready), 64'd0);
    tick();
    tick();
    tick();
    check("stall_hold_addr", 64'(instruction.address), 64'h1000);
    check("stall_hold_valid", 64'(instr_valid), 64'd1);
    check("stall_ready", 64'(cmd_in_ready), 64'd0);
    proc_done = 1'b1;
    tick();
    tick();
    check("ready_returns", 64'(cmd_in_ready), 64'd1);
    drain("full_drain");
    check("full_sb_empty", 64'(exp_q.size()), 64'd0);

    // n = 0, 8, 9, 5: issue, clear handshake, print pulse, illegal drop.
    proc_done = 1'b0;
    clr_cnt = 0;
    prt_cnt = 0;
    ill_cnt = 0;
    push(4'd0, 32'h2000);
    push(4'd8, 32'h2001);
    push(4'd9, 32'h2002);
    push(4'd5, 32'h2003);
    tick();
    tick();
    check("seq_no_clear_yet", 64'(clr_cnt), 64'd0);
    check("seq_issue_held", 64'(instr_valid), 64'd1);
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("seq_clear_once", 64'(clr_cnt), 64'd1);
    check("seq_clear_no_valid", 64'(instr_valid), 64'd0);
    check("seq_clear_instr_n", 64'(instruction.n), 64'd8);
    check("seq_clear_keeps_fifo", 64'(fifo_count), 64'd2);
    check("seq_clear_waiting", 64'(busy), 64'd1);
    check("seq_no_print_yet", 64'(prt_cnt), 64'd0);
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("seq_print_once", 64'(prt_cnt), 64'd1);
    check("seq_illegal_once", 64'(ill_cnt), 64'd1);
    check("seq_clear_total", 64'(clr_cnt), 64'd1);
    check("seq_idle", 64'(busy), 64'd0);
    check("seq_sb_empty", 64'(exp_q.size()), 64'd0);

    // Simultaneous push/pop at count 4, then 20 addresses through the wrap.
    proc_done = 1'b0;
    for (int i = 0; i < 5; i++) push(4'(i % 5), 32'h3000 + 32'(i));
    check("pp_count_before", 64'(fifo_count), 64'd4);
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    c = '{n: 4'd0, address: 32'h3005, pid: 3'd5, rsvd: 2'b00};
    cmd_in       = c;
    cmd_in_valid = 1'b1;
    check("pp_ready", 64'(cmd_in_ready), 64'd1);
    exp_q.push_back(c);
    tick();
    cmd_in_valid = 1'b0;
    check("pp_count_same", 64'(fifo_count), 64'd4);
    proc_done = 1'b1;
    for (int i = 6; i < 20; i++) push(4'(i % 5), 32'h3000 + 32'(i));
    drain("wrap_drain");
    check("wrap_sb_empty", 64'(exp_q.size()), 64'd0);

    // Reset while an instruction is in flight and 3 entries are queued.
    proc_done = 1'b0;
    for (int i = 0; i < 4; i++) push(4'd2, 32'h4000 + 32'(i));
    check("mid_count", 64'(fifo_count), 64'd3);
    check("mid_valid", 64'(instr_valid), 64'd1);
    clr_cnt = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_count", 64'(fifo_count), 64'd0);
    check("mid_rst_valid", 64'(instr_valid), 64'd0);
    check("mid_rst_ready", 64'(cmd_in_ready), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_instr", 64'(instruction), 64'd0);
    tick();
    check("mid_rst_no_pulse", 64'(clr_cnt), 64'd0);

    proc_done = 1'b1;
`ifdef TRACE_DISPATCH_STATS_EN
    push(4'd0, 32'h5000);
    push(4'd0, 32'h5001);
    push(4'd0, 32'h5002);
    push(4'd1, 32'h5003);
    push(4'd1, 32'h5004);
    push(4'd2, 32'h5005);
    drain("stats_drain");
    check("stats_rd", 64'(rd_cnt), 64'd3);
    check("stats_wr", 64'(wr_cnt), 64'd2);
    check("stats_if", 64'(if_cnt), 64'd1);
    push(4'd8, 32'h5006);
    drain("stats_clear_drain");
    check("stats_rd_cleared", 64'(rd_cnt), 64'd0);
    check("stats_wr_cleared", 64'(wr_cnt), 64'd0);
    check("stats_if_cleared", 64'(if_cnt), 64'd0);
`else
    push(4'd0, 32'h5000);
    push(4'd1, 32'h5001);
    push(4'd2, 32'h5002);
    drain("nostats_drain");
    check("nostats_rd", 64'(rd_cnt), 64'd0);
    check("nostats_wr", 64'(wr_cnt), 64'd0);
    check("nostats_if", 64'(if_cnt), 64'd0);
`endif
    check("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trace_cmd_dispatch.md
Name: trace_cmd_dispatch

Overview:
- Upstream stage of `processor`. It buffers trace commands from the trace-file reader in a FIFO and issues them one at a time on the `instruction` input, using a done handshake.
- Decodes the command code `n`:
  - 0, 1, 2, 3, 4 are normal cache operations.
  - 8 (clear cache and reset state) and 9 (print contents) are converted to side-band request pulses.
  - Any other code is dropped and flagged.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- CNT_W, 16, width of statistic counters (optional feature).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- cmd_in  in  command_t  trace command {n[3:0], address[31:0], pid[2:0], rsvd[1:0]}
- cmd_in_valid  in  1  cmd_in is valid this cycle
- cmd_in_ready  out  1  dispatcher can accept cmd_in
- instruction  out  command_t  command presented to processor
- instr_valid  out  1  instruction is valid; held until proc_done
- proc_done  in  1  processor finished current instruction / clear
- clear_req  out  1  one-cycle pulse for n=8
- print_req  out  1  one-cycle pulse for n=9
- illegal_cmd  out  1  one-cycle pulse: popped command had an unsupported n
- fifo_count  out  $clog2(DEPTH)+1  entries currently held
- busy  out  1  FSM not IDLE or FIFO non-empty
- rd_cnt, wr_cnt, if_cnt  out  CNT_W each  statistics (optional feature)

Behaviour:
- Reset: synchronous, active-high, sampled on the rising edge of clk.
  - FIFO is flushed: count=0, pointers=0.
  - FSM goes to IDLE.
  - Outputs after reset: instruction=0, instr_valid=0, clear_req=0, print_req=0, illegal_cmd=0, fifo_count=0, busy=0.
  - Asserting rst mid-operation abandons the in-flight command without issuing proc-side pulses.
- FIFO:
  - `cmd_in_ready = (count != DEPTH)`, combinational from registered count.
  - Push on `cmd_in_valid && cmd_in_ready`.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - No bypass: minimum latency is 2 edges (accept at edge E, instruction/instr_valid registered at edge E+1).
- FSM states: IDLE, ISSUE, CLEAR, PRINT.
  - **IDLE**: if count>0, pop the head and decode n.
    - n∈{0,1,2,3,4}: load instruction, set instr_valid=1, go to ISSUE.
    - n=8: load instruction, pulse clear_req, go to CLEAR.
    - n=9: load instruction, pulse print_req, go to PRINT.
    - Other n: pulse illegal_cmd, discard, stay in IDLE.
  - **ISSUE**: hold instruction and instr_valid stable until proc_done=1. On that edge: instr_valid←0, go to IDLE. This gives one bubble cycle before the next issue.
  - **CLEAR**: instr_valid stays 0. Wait for proc_done; on that edge go to IDLE. The FIFO contents are preserved; clear is a cache reset, not a queue flush.
  - **PRINT**: unconditionally return to IDLE next edge; no handshake.
  - proc_done is ignored in IDLE and PRINT.
- All pulse outputs are high for exactly one cycle and are registered.
- While the FSM is stalled, a full FIFO holds cmd_in_ready=0. The upstream source must hold cmd_in stable while cmd_in_valid=1 and cmd_in_ready=0.

Optional Feature:
- Macro: TRACE_DISPATCH_STATS_EN.
- Defined:
  - rd_cnt, wr_cnt, if_cnt count issued n=0, 1, 2 respectively.
  - Each increments on the IDLE→ISSUE pop edge.
  - Each saturates at 2^CNT_W−1.
  - All clear on rst and on a clear_req pulse.
- Undefined: ports remain, tied to 0; no counter flops are synthesized.

Decomposition:
- my_struct_package (shared) holds:
  - command_t, with fields n, address, pid, rsvd.
  - dispatch_state_t enum.
  - Localparams CMD_READ=0, CMD_WRITE=1, CMD_IFETCH=2, CMD_INVAL=3, CMD_SNOOP=4, CMD_CLEAR=8, CMD_PRINT=9.
- Sub-module: cmd_fifo (parameterised DEPTH, command_t payload, count output). The FSM and counters stay in trace_cmd_dispatch.

Test Plan:
- Reset mid-ISSUE, with a FIFO holding 3 entries → next cycle: fifo_count=0, instr_valid=0, cmd_in_ready=1, busy=0.
- Push {n=1, addr=32'hABCD_EF01} at edge E with proc_done tied high →
  - instr_valid=1 with that address after edge E+1;
  - instr_valid=0 after E+2.
- Push 9 commands with proc_done held 0 →
  - cmd_in_ready=0 after fifo_count=8;
  - first command held on instruction;
  - raise proc_done → ready returns; all 9 issued in order.
- Sequence n=0, 8, 9, 5 →
  - one ISSUE;
  - clear_req pulse for 1 cycle, waits for proc_done, instr_valid=0;
  - print_req pulse for 1 cycle;
  - illegal_cmd pulse for 1 cycle; n=5 never appears with instr_valid.
- Simultaneous push and pop with fifo_count=4 → fifo_count stays 4; FIFO order preserved across pointer wrap (push 20 distinct addresses).
- With TRACE_DISPATCH_STATS_EN: 3 reads, 2 writes, 1 ifetch → rd_cnt=3, wr_cnt=2, if_cnt=1; then n=8 → all counters 0.
